// File: rtl/bcd_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// bcd_pkg : shared BCD digit type, FSM encoding and nines-complement helper
// Rev 1.0
// ============================================================================
package bcd_pkg;

  typedef logic [3:0] bcd_digit_t;

  localparam bcd_digit_t BCD_MAX = 4'd9;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } bcd_state_e;

  // Invalid digits (>9) wrap; the result is then unspecified but deterministic.
  function automatic bcd_digit_t nines(input bcd_digit_t d);
    return BCD_MAX - d;
  endfunction

endpackage
`default_nettype wire

// File: rtl/bcd_serial_alu_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// bcd_serial_alu_if : request/response bundle of the digit-serial BCD unit
// Rev 1.0
// ============================================================================
interface bcd_serial_alu_if #(
  parameter int NUM_DIGITS = 4
);
  localparam int W = 4 * NUM_DIGITS;

  logic         in_valid;
  logic         in_ready;
  logic         op_sub;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         carry_in;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic         carry_out;
  logic         zero;
  logic         bad_digit;

  modport master (
    output in_valid, op_sub, a, b, carry_in, out_ready,
    input  in_ready, out_valid, result, carry_out, zero, bad_digit
  );

  modport slave (
    input  in_valid, op_sub, a, b, carry_in, out_ready,
    output in_ready, out_valid, result, carry_out, zero, bad_digit
  );
endinterface
`default_nettype wire

// File: rtl/bcd_digit_add.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// bcd_digit_add : combinational single BCD digit adder with carry in/out
// Rev 1.0
// ============================================================================
module bcd_digit_add
  import bcd_pkg::*;
(
  input  bcd_digit_t a,
  input  bcd_digit_t b,
  input  logic       cin,
  output bcd_digit_t sum,
  output logic       cout
);

  logic [4:0] raw;
  logic [4:0] adj;

  always_comb begin
    raw  = {1'b0, a} + {1'b0, b} + {4'd0, cin};
    adj  = raw - 5'd10;
    sum  = raw[3:0];
    cout = 1'b0;
    if (raw > {1'b0, BCD_MAX}) begin
      sum  = adj[3:0];
      cout = 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/bcd_serial_alu.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// bcd_serial_alu : digit-serial BCD add/subtract, DIGITS_PER_CYCLE digits per
// clock, least-significant first. Input digit check enabled by BCD_DIGIT_CHECK_EN.
// Rev 1.0
// ============================================================================
module bcd_serial_alu
  import bcd_pkg::*;
#(
  parameter int NUM_DIGITS       = 4,
  parameter int DIGITS_PER_CYCLE = 1
) (
  input  logic            clk,
  input  logic            rst,
  bcd_serial_alu_if.slave bus
);

  localparam int W     = 4 * NUM_DIGITS;
  localparam int GW    = 4 * DIGITS_PER_CYCLE;
  localparam int STEPS = NUM_DIGITS / DIGITS_PER_CYCLE;
  localparam int CW    = (STEPS > 1) ? $clog2(STEPS) : 1;
  localparam logic [CW-1:0] LAST = CW'(STEPS - 1);

  if ((DIGITS_PER_CYCLE < 1) || (NUM_DIGITS % DIGITS_PER_CYCLE != 0)) begin : g_cfg_check
    $error("bcd_serial_alu: DIGITS_PER_CYCLE must divide NUM_DIGITS");
  end

  bcd_state_e    state;
  bcd_state_e    state_next;
  logic          in_ready_c;
  logic          out_valid_c;
  logic [CW-1:0] cnt;
  logic [W-1:0]  sa;
  logic [W-1:0]  sb;
  logic [W-1:0]  acc;
  logic [W-1:0]  acc_next;
  logic          carry;
  logic [W-1:0]  result_reg;
  logic          carry_out_reg;
  logic          zero_reg;
  logic [W-1:0]  b_nines;
  logic [GW-1:0] grp_sum;
  logic [DIGITS_PER_CYCLE:0] chain;
  logic          accept;
  logic          last_step;

  assign accept    = (state == IDLE) && bus.in_valid;
  assign last_step = (state == RUN) && (cnt == LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next  = state;
    in_ready_c  = 1'b0;
    out_valid_c = 1'b0;
    case (state)
      IDLE: begin
        in_ready_c = 1'b1;
        if (bus.in_valid) state_next = RUN;
      end
      RUN: begin
        if (cnt == LAST) state_next = DONE;
      end
      DONE: begin
        out_valid_c = 1'b1;
        if (bus.out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  for (genvar d = 0; d < NUM_DIGITS; d++) begin : g_nines
    assign b_nines[4*d +: 4] = nines(bus.b[4*d +: 4]);
  end

  // Carry ripples through the digit group within a cycle, then is held in 'carry'.
  assign chain[0] = carry;
  for (genvar i = 0; i < DIGITS_PER_CYCLE; i++) begin : g_digit
    bcd_digit_add u_add (
      .a    (sa[4*i +: 4]),
      .b    (sb[4*i +: 4]),
      .cin  (chain[i]),
      .sum  (grp_sum[4*i +: 4]),
      .cout (chain[i+1])
    );
  end

  always_comb begin
    acc_next = acc >> GW;
    acc_next[W-1 -: GW] = grp_sum;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt           <= '0;
      sa            <= '0;
      sb            <= '0;
      acc           <= '0;
      carry         <= 1'b0;
      result_reg    <= '0;
      carry_out_reg <= 1'b0;
      zero_reg      <= 1'b0;
    end else if (accept) begin
      sa    <= bus.a;
      sb    <= bus.op_sub ? b_nines : bus.b;
      carry <= bus.carry_in;
      cnt   <= '0;
    end else if (state == RUN) begin
      sa    <= sa >> GW;
      sb    <= sb >> GW;
      acc   <= acc_next;
      carry <= chain[DIGITS_PER_CYCLE];
      cnt   <= cnt + CW'(1);
      if (last_step) begin
        result_reg    <= acc_next;
        carry_out_reg <= chain[DIGITS_PER_CYCLE];
        zero_reg      <= (acc_next == '0);
      end
    end
  end

`ifdef BCD_DIGIT_CHECK_EN
  logic [2*NUM_DIGITS-1:0] digit_bad;
  logic                    bad_pend;
  logic                    bad_out;

  for (genvar d = 0; d < NUM_DIGITS; d++) begin : g_digit_check
    assign digit_bad[2*d]   = bus.a[4*d +: 4] > BCD_MAX;
    assign digit_bad[2*d+1] = bus.b[4*d +: 4] > BCD_MAX;
  end

  // Flag is captured at accept but only published alongside its own result.
  always_ff @(posedge clk) begin
    if (rst) begin
      bad_pend <= 1'b0;
      bad_out  <= 1'b0;
    end else if (accept) begin
      bad_pend <= |digit_bad;
    end else if (last_step) begin
      bad_out  <= bad_pend;
    end
  end

  assign bus.bad_digit = bad_out;
`else
  assign bus.bad_digit = 1'b0;
`endif

  assign bus.in_ready  = in_ready_c;
  assign bus.out_valid = out_valid_c;
  assign bus.result    = result_reg;
  assign bus.carry_out = carry_out_reg;
  assign bus.zero      = zero_reg;

endmodule
`default_nettype wire

// File: tb/tb_bcd_serial_alu.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// tb_bcd_serial_alu : scoreboard bench for 4x1 and 8x2 digit configurations
// Rev 1.0
// ============================================================================
module tb_bcd_serial_alu;

  typedef struct {
    logic [31:0] res;
    logic        co;
    logic        z;
    logic        bad;
    bit          chk_res;
    int          lat;
  } exp_t;

`ifdef BCD_DIGIT_CHECK_EN
  localparam logic BAD_EXP = 1'b1;
`else
  localparam logic BAD_EXP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_vec = 0;
  int   n_err = 0;

  exp_t q4[$];
  exp_t q8[$];
  int   acc4[$];
  int   acc8[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  bcd_serial_alu_if #(.NUM_DIGITS(4)) bus4 ();
  bcd_serial_alu_if #(.NUM_DIGITS(8)) bus8 ();

  bcd_serial_alu #(.NUM_DIGITS(4), .DIGITS_PER_CYCLE(1)) dut4 (
    .clk (clk),
    .rst (rst),
    .bus (bus4)
  );

  bcd_serial_alu #(.NUM_DIGITS(8), .DIGITS_PER_CYCLE(2)) dut8 (
    .clk (clk),
    .rst (rst),
    .bus (bus8)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: actual %0h required %0h", name, act, req);
    end
  endtask

  function automatic exp_t mk(input logic [31:0] res, input logic co, input logic z,
                              input logic bad, input bit chk_res, input int lat);
    exp_t e;
    e.res = res; e.co = co; e.z = z; e.bad = bad; e.chk_res = chk_res; e.lat = lat;
    return e;
  endfunction

  always @(negedge clk) begin
    exp_t e;
    int   t0;
    if (!rst) begin
      if (bus4.in_valid && bus4.in_ready) acc4.push_back(cyc);
      if (bus4.out_valid && bus4.out_ready) begin
        if (q4.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL spurious_out4: actual result %0h required no output", bus4.result);
        end else begin
          e  = q4.pop_front();
          t0 = (acc4.size() > 0) ? acc4.pop_front() : -100;
          if (e.chk_res) check("result4", {16'd0, bus4.result}, e.res);
          check("carry_out4", {31'd0, bus4.carry_out}, {31'd0, e.co});
          check("zero4",      {31'd0, bus4.zero},      {31'd0, e.z});
          check("bad_digit4", {31'd0, bus4.bad_digit}, {31'd0, e.bad});
          if (e.lat >= 0) check("latency4", cyc - t0, e.lat);
        end
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    int   t0;
    if (!rst) begin
      if (bus8.in_valid && bus8.in_ready) acc8.push_back(cyc);
      if (bus8.out_valid && bus8.out_ready) begin
        if (q8.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL spurious_out8: actual result %0h required no output", bus8.result);
        end else begin
          e  = q8.pop_front();
          t0 = (acc8.size() > 0) ? acc8.pop_front() : -100;
          check("result8",    bus8.result,             e.res);
          check("carry_out8", {31'd0, bus8.carry_out}, {31'd0, e.co});
          check("zero8",      {31'd0, bus8.zero},      {31'd0, e.z});
          if (e.lat >= 0) check("latency8", cyc - t0, e.lat);
        end
      end
    end
  end

  task automatic issue(input bit wide, input bit sub, input logic [31:0] a,
                       input logic [31:0] b, input bit cin, input bit push, input exp_t e);
    bit ok = 1'b0;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(posedge clk); #1;
      ok = wide ? (bus8.in_ready === 1'b1) : (bus4.in_ready === 1'b1);
    end
    if (!ok) begin
      n_vec++; n_err++;
      $display("FAIL issue_timeout: actual in_ready low required high within 50 cycles");
      return;
    end
    if (wide) begin
      bus8.in_valid = 1'b1; bus8.op_sub = sub; bus8.a = a; bus8.b = b; bus8.carry_in = cin;
      if (push) q8.push_back(e);
    end else begin
      bus4.in_valid = 1'b1; bus4.op_sub = sub; bus4.a = a[15:0]; bus4.b = b[15:0];
      bus4.carry_in = cin;
      if (push) q4.push_back(e);
    end
    @(posedge clk); #1;
    bus4.in_valid = 1'b0;
    bus8.in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    bit done = 1'b0;
    for (int i = 0; i < 100 && !done; i++) begin
      @(posedge clk); #1;
      done = (q4.size() == 0) && (q8.size() == 0);
    end
    if (!done) begin
      n_vec++; n_err++;
      $display("FAIL drain_timeout: actual %0d/%0d pending required 0/0", q4.size(), q8.size());
    end
  endtask

  initial begin
    bit seen;
    bus4.in_valid = 1'b0; bus4.op_sub = 1'b0; bus4.a = '0; bus4.b = '0;
    bus4.carry_in = 1'b0; bus4.out_ready = 1'b1;
    bus8.in_valid = 1'b0; bus8.op_sub = 1'b0; bus8.a = '0; bus8.b = '0;
    bus8.carry_in = 1'b0; bus8.out_ready = 1'b1;

    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check("rst_in_ready",  {31'd0, bus4.in_ready},  32'd1);
    check("rst_out_valid", {31'd0, bus4.out_valid}, 32'd0);
    check("rst_result",    {16'd0, bus4.result},    32'd0);
    check("rst_carry_out", {31'd0, bus4.carry_out}, 32'd0);
    check("rst_zero",      {31'd0, bus4.zero},      32'd0);
    check("rst_bad_digit", {31'd0, bus4.bad_digit}, 32'd0);

    issue(0, 0, 32'h1234, 32'h5678, 0, 1, mk(32'h6912, 0, 0, 0, 1, 5));
    issue(0, 0, 32'h9999, 32'h0001, 0, 1, mk(32'h0000, 1, 1, 0, 1, 5));
    issue(0, 0, 32'h9999, 32'h9999, 1, 1, mk(32'h9999, 1, 0, 0, 1, 5));
    issue(0, 1, 32'h0100, 32'h0001, 1, 1, mk(32'h0099, 1, 0, 0, 1, 5));
    issue(0, 1, 32'h0001, 32'h0002, 1, 1, mk(32'h9999, 0, 0, 0, 1, 5));
    issue(0, 1, 32'h5000, 32'h2500, 1, 1, mk(32'h2500, 1, 0, 0, 1, 5));
    issue(0, 0, 32'h0000, 32'h0000, 0, 1, mk(32'h0000, 0, 1, 0, 1, 5));
    issue(0, 0, 32'h00A0, 32'h0001, 0, 1, mk(32'h0000, 0, 0, BAD_EXP, 0, 5));
    issue(0, 0, 32'h0042, 32'h0058, 0, 1, mk(32'h0100, 0, 0, 0, 1, 5));

    issue(1, 0, 32'h99999999, 32'h00000001, 0, 1, mk(32'h00000000, 1, 1, 0, 1, 5));
    issue(1, 0, 32'h12345678, 32'h87654321, 0, 1, mk(32'h99999999, 0, 0, 0, 1, 5));
    wait_drain();

    // Backpressure: result must hold and new requests must be ignored.
    bus4.out_ready = 1'b0;
    issue(0, 0, 32'h4321, 32'h1111, 0, 1, mk(32'h5432, 0, 0, 0, 1, -1));
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      seen = (bus4.out_valid === 1'b1);
      if (!seen) begin @(posedge clk); #1; end
    end
    if (!seen) begin
      n_vec++; n_err++;
      $display("FAIL bp_out_valid_timeout: actual out_valid low required high");
    end
    for (int k = 0; k < 3; k++) begin
      check("bp_out_valid", {31'd0, bus4.out_valid}, 32'd1);
      check("bp_result",    {16'd0, bus4.result},    32'h5432);
      check("bp_in_ready",  {31'd0, bus4.in_ready},  32'd0);
      bus4.in_valid = 1'b1; bus4.a = 16'h9999; bus4.b = 16'h9999; bus4.carry_in = 1'b1;
      @(posedge clk); #1;
    end
    bus4.in_valid  = 1'b0;
    bus4.out_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_release_in_ready",  {31'd0, bus4.in_ready},  32'd1);
    check("bp_release_out_valid", {31'd0, bus4.out_valid}, 32'd0);
    wait_drain();

    // Reset in the second RUN cycle discards the operation.
    issue(0, 0, 32'h1234, 32'h1111, 0, 0, mk(32'h0, 0, 0, 0, 0, -1));
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    acc4.delete();
    check("mid_rst_in_ready",  {31'd0, bus4.in_ready},  32'd1);
    check("mid_rst_out_valid", {31'd0, bus4.out_valid}, 32'd0);
    check("mid_rst_result",    {16'd0, bus4.result},    32'd0);
    check("mid_rst_carry_out", {31'd0, bus4.carry_out}, 32'd0);
    check("mid_rst_zero",      {31'd0, bus4.zero},      32'd0);
    issue(0, 0, 32'h0005, 32'h0005, 0, 1, mk(32'h0010, 0, 0, 0, 1, 5));
    wait_drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/bcd_serial_alu.md
Name: bcd_serial_alu

Overview:
- Parametrised, digit-serial BCD add/subtract unit; successor to the combinational 4-digit DADD datapath.
- Processes DIGITS_PER_CYCLE packed-BCD digits per clock, least-significant first, for operands of NUM_DIGITS digits.
- Valid/ready on both input and output.
- Sits beside the execute-stage ALU; used for wide or multi-cycle decimal ops so the single-cycle critical path stays short.

Parameters:
- NUM_DIGITS, 4, BCD digits per operand; operand width W = 4*NUM_DIGITS.
- DIGITS_PER_CYCLE, 1, digits processed per RUN cycle; must divide NUM_DIGITS exactly (elaboration-time assertion).

Ports:
- clk  in  1  Clock.
- rst  in  1  Reset.
- in_valid  in  1  Operation request.
- in_ready  out  1  Unit can accept a request.
- op_sub  in  1  0 = DADD (a+b+cin); 1 = DSUB (a + nines(b) + cin).
- a  in  W  BCD operand A.
- b  in  W  BCD operand B.
- carry_in  in  1  Carry in.
- out_valid  out  1  Result available.
- out_ready  in  1  Consumer accepts result.
- result  out  W  BCD result.
- carry_out  out  1  Final decimal carry; on DSUB, 1 = no borrow.
- zero  out  1  result == 0.
- bad_digit  out  1  Operand contained a digit > 9 (optional feature only; otherwise tied 0).

Behaviour:
- One clock; reset is synchronous and active-high.
- Reset values:
  - in_ready=1, out_valid=0, result=0, carry_out=0, zero=0, bad_digit=0.
  - FSM=IDLE, digit counter=0.
- FSM states:
  - IDLE: in_ready=1. On in_valid&&in_ready:
    - Latch a into shift register SA.
    - Latch SB = op_sub ? nines(b) : b, where nines(d) = 9-d per digit.
    - Latch carry = carry_in, counter = 0; go to RUN.
  - RUN: in_ready=0. Each cycle, for the DIGITS_PER_CYCLE low digits, chain carry digit to digit:
    - s = SA_d + SB_d + c, 5-bit.
    - If s > 9: digit = s - 10, c = 1. Else: digit = s, c = 0.
    - The carry chains across digits in the group and across cycles.
    - Shift SA/SB right and shift result digits in from the top; counter += 1.
    - When counter == NUM_DIGITS/DIGITS_PER_CYCLE - 1, go to DONE next cycle with result, carry_out and zero registered.
  - DONE: out_valid=1, in_ready=0. On out_ready, go to IDLE; out_valid falls the next cycle.
- Latency: accept edge to out_valid = NUM_DIGITS/DIGITS_PER_CYCLE + 1 cycles (defaults: 5). Throughput is one op per latency + 1 cycles with out_ready held high.
- result, carry_out, zero and bad_digit are held stable throughout DONE regardless of out_ready.
- in_valid is ignored outside IDLE; no queueing.
- Wrap-around:
  - 9999+0001 gives 0000 with carry_out=1.
  - carry_in=1 on 9999+9999 gives 9999 with carry_out=1.
- Reset mid-RUN or in DONE: abort immediately to reset values; the partial result is discarded.
- Invalid digits without the optional feature: same arithmetic (s-10 when s>9, carry out of a digit is 0 or 1); result is unspecified but deterministic.

Optional Feature:
- Macro: BCD_DIGIT_CHECK_EN.
- Defined:
  - On accept, bad_digit is computed over all digits of a and b (before the nines complement) and registered.
  - It is presented with out_valid in DONE.
  - The operation still runs to completion.
- Undefined: bad_digit is constant 0 and no check logic is generated.

Decomposition:
- Shared package bcd_pkg:
  - typedef bcd_digit_t (logic[3:0]).
  - constant BCD_MAX = 4'd9.
  - FSM enum bcd_state_e {IDLE, RUN, DONE}.
  - function nines(bcd_digit_t).
- Sub-module bcd_digit_add: combinational single-digit adder (a, b, cin -> sum digit, cout), instantiated DIGITS_PER_CYCLE times in a chain.

Test Plan:
- DADD 0x1234 + 0x5678, cin=0 (defaults) -> out_valid exactly 5 cycles after accept; result=0x6912, carry_out=0, zero=0.
- DADD 0x9999 + 0x0001, cin=0 -> result=0x0000, carry_out=1, zero=1; repeat with NUM_DIGITS=8, DIGITS_PER_CYCLE=2 on 0x99999999 + 0x00000001 -> 0x00000000, carry_out=1, latency 5.
- DSUB 0x0100 - 0x0001, cin=1 -> 0x0099, carry_out=1; DSUB 0x0001 - 0x0002, cin=1 -> 0x9999, carry_out=0.
- Backpressure: out_ready low for 3 cycles in DONE -> result/out_valid stable, in_ready=0, in_valid pulses ignored; out_ready high -> IDLE next cycle, in_ready=1.
- Assert rst during the 2nd RUN cycle -> next cycle all outputs at reset values and state IDLE; a following op 0x0005 + 0x0005 -> 0x0010 correct.
- With BCD_DIGIT_CHECK_EN: a=0x00A0, b=0x0001 -> bad_digit=1 in DONE; a valid op afterwards -> bad_digit=0. Without the macro -> bad_digit=0 always.
